// File: rtl/alarm_bank.sv
// Multi-channel alarm bank. Each channel stores an hour, a minute and an
// enable bit, which are edited through the selected-channel pulses. A single
// IDLE/RING/SNOOZE controller rings for the lowest enabled channel whose time
// matches at the top of a minute. One down-counter times both the ring and
// the snooze period.
module alarm_bank #(
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  localparam int CW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [4:0]    cur_hour,
  input  logic [5:0]    cur_min,
  input  logic [5:0]    cur_sec,
  input  logic [CW-1:0] sel,
  input  logic          inc_min,
  input  logic          inc_hour,
  input  logic          en_toggle,
  input  logic          stop,
  input  logic          snooze,
  output logic [4:0]    disp_hour,
  output logic [5:0]    disp_min,
  output logic          disp_en,
  output logic          ring,
  output logic          led,
  output logic [CW-1:0] ring_ch
);

  // The counter only has to hold the longer of the two periods minus one.
  localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNTW-1:0] RING_LOAD   = CNTW'(RING_SECS - 1);
  localparam logic [CNTW-1:0] SNOOZE_LOAD = CNTW'(SNOOZE_SECS - 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;

  logic [4:0] hour_q [NUM_ALARMS];
  logic [5:0] min_q  [NUM_ALARMS];
  logic       en_q   [NUM_ALARMS];

  logic          any_match;
  logic [CW-1:0] match_ch;
  logic          kill;

  // Alarm storage: the selected channel takes every edit pulse present this cycle.
  // NOTE: the alarm table is a handful of flops, not a RAM, so it is reset
  // explicitly; reset must leave every channel at 00:00 and disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hour_q[i] <= '0;
        min_q[i]  <= '0;
        en_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        // An out-of-range sel equals no channel index, so its edits are dropped.
        if (sel == CW'(i)) begin
          if (inc_min)
            min_q[i] <= (min_q[i] == 6'd59) ? 6'd0 : min_q[i] + 6'd1;
          if (inc_hour)
            hour_q[i] <= (hour_q[i] == 5'd23) ? 5'd0 : hour_q[i] + 5'd1;
          if (en_toggle)
            en_q[i] <= ~en_q[i];
        end
      end
    end
  end

  // Display mux: zero-latency view of the selected channel, zero when out of range.
  // NOTE: every output of a combinational block gets a default first so that a
  // path which assigns nothing cannot infer a latch.
  always_comb begin
    disp_hour = '0;
    disp_min  = '0;
    disp_en   = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel == CW'(i)) begin
        disp_hour = hour_q[i];
        disp_min  = min_q[i];
        disp_en   = en_q[i];
      end
    end
  end

  // Match detect: scanning downward leaves the lowest matching index in match_ch.
  always_comb begin
    any_match = 1'b0;
    match_ch  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (tick && (cur_sec == 6'd0) && en_q[i] &&
          (cur_hour == hour_q[i]) && (cur_min == min_q[i])) begin
        any_match = 1'b1;
        match_ch  = CW'(i);
      end
    end
  end

  // Disabling the channel that owns the active ring/snooze cancels it like stop.
  always_comb begin
    kill = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (en_toggle && (sel == CW'(i)) && (ring_ch == CW'(i)) && en_q[i])
        kill = 1'b1;
    end
  end

  // Ring controller with registered ring/led/ring_ch; stop beats snooze beats tick.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ring    <= 1'b0;
      led     <= 1'b0;
      ring_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_match) begin
            state   <= RING;
            cnt     <= RING_LOAD;
            ring    <= 1'b1;
            led     <= 1'b1;
            ring_ch <= match_ch;
          end
        end
        RING: begin
          if (stop || kill) begin
            state <= IDLE;
            cnt   <= '0;
            ring  <= 1'b0;
            led   <= 1'b0;
          end else if (snooze) begin
            state <= SNOOZE;
            cnt   <= SNOOZE_LOAD;
            ring  <= 1'b0;
            led   <= 1'b0;
          end else if (tick) begin
            if (cnt == '0) begin
              state <= IDLE;
              ring  <= 1'b0;
              led   <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
              led <= ~led;
            end
          end
        end
        SNOOZE: begin
          if (stop || kill) begin
            state <= IDLE;
            cnt   <= '0;
            ring  <= 1'b0;
            led   <= 1'b0;
          end else if (tick) begin
            if (cnt == '0) begin
              state <= RING;
              cnt   <= RING_LOAD;
              ring  <= 1'b1;
              led   <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          ring  <= 1'b0;
          led   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank. Instance a uses the 4-channel configuration for the
// ring/snooze scenarios; instance b has 5 channels so that sel=5 is a
// representable out-of-range selector. Stimulus pushes expected output
// vectors into a queue; a monitor pops and compares them on the falling edge.
module tb_alarm_bank;

  logic clk;
  logic rst_n;
  logic tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic stop, snooze;

  logic [1:0] sel_a;
  logic inc_min_a, inc_hour_a, en_toggle_a;
  logic [4:0] dh_a;
  logic [5:0] dm_a;
  logic den_a, ring_a, led_a;
  logic [1:0] ring_ch_a;

  logic [2:0] sel_b;
  logic inc_min_b, inc_hour_b, en_toggle_b;
  logic [4:0] dh_b;
  logic [5:0] dm_b;
  logic den_b, ring_b, led_b;
  logic [2:0] ring_ch_b;

  alarm_bank #(.NUM_ALARMS(4), .RING_SECS(5), .SNOOZE_SECS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .sel(sel_a), .inc_min(inc_min_a), .inc_hour(inc_hour_a),
    .en_toggle(en_toggle_a), .stop(stop), .snooze(snooze),
    .disp_hour(dh_a), .disp_min(dm_a), .disp_en(den_a),
    .ring(ring_a), .led(led_a), .ring_ch(ring_ch_a)
  );

  alarm_bank #(.NUM_ALARMS(5), .RING_SECS(5), .SNOOZE_SECS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .sel(sel_b), .inc_min(inc_min_b), .inc_hour(inc_hour_b),
    .en_toggle(en_toggle_b), .stop(stop), .snooze(snooze),
    .disp_hour(dh_b), .disp_min(dm_b), .disp_en(den_b),
    .ring(ring_b), .led(led_b), .ring_ch(ring_ch_b)
  );

  // Expected vector layout: {ring, led, ring_ch[2:0], hour[4:0], min[5:0], en}
  typedef struct {
    string       name;
    bit          dut;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input exp_t e, input logic [16:0] act);
    total++;
    if (act !== e.v) begin
      bad++;
      $display("FAIL %s: got ring=%0b led=%0b ch=%0d %0d:%0d en=%0b, expected ring=%0b led=%0b ch=%0d %0d:%0d en=%0b",
               e.name, act[16], act[15], act[14:12], act[11:7], act[6:1], act[0],
               e.v[16], e.v[15], e.v[14:12], e.v[11:7], e.v[6:1], e.v[0]);
    end
  endtask

  // Monitor: drains every queued expectation against the live outputs.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut)
        check(e, {ring_b, led_b, ring_ch_b, dh_b, dm_b, den_b});
      else
        check(e, {ring_a, led_a, 1'b0, ring_ch_a, dh_a, dm_a, den_a});
    end
  end

  task automatic exp_a(input string n, input logic r, input logic l, input int ch,
                       input int h, input int m, input logic en);
    exp_t e;
    e.name = n;
    e.dut  = 1'b0;
    e.v    = {r, l, 3'(ch), 5'(h), 6'(m), en};
    sb.push_back(e);
  endtask

  task automatic exp_b(input string n, input int h, input int m, input logic en);
    exp_t e;
    e.name = n;
    e.dut  = 1'b1;
    e.v    = {1'b0, 1'b0, 3'd0, 5'(h), 6'(m), en};
    sb.push_back(e);
  endtask

  // Let the monitor consume what was pushed, before the next rising edge.
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // One rising edge with the currently driven inputs; pulses drop afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0;
    stop = 1'b0;
    snooze = 1'b0;
    inc_min_a = 1'b0;
    inc_hour_a = 1'b0;
    en_toggle_a = 1'b0;
    inc_min_b = 1'b0;
    inc_hour_b = 1'b0;
    en_toggle_b = 1'b0;
  endtask

  task automatic do_tick(input int h, input int m, input int s);
    cur_hour = 5'(h);
    cur_min  = 6'(m);
    cur_sec  = 6'(s);
    tick     = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick = 1'b0; stop = 1'b0; snooze = 1'b0;
    cur_hour = '0; cur_min = '0; cur_sec = '0;
    sel_a = 2'd0; inc_min_a = 1'b0; inc_hour_a = 1'b0; en_toggle_a = 1'b0;
    sel_b = 3'd7; inc_min_b = 1'b0; inc_hour_b = 1'b0; en_toggle_b = 1'b0;

    // Reset state
    repeat (2) step();
    exp_a("rst_state", 0, 0, 0, 0, 0, 0);
    exp_b("rst_state_b", 0, 0, 0);
    sample();
    rst_n = 1'b1;
    step();
    exp_a("post_rst", 0, 0, 0, 0, 0, 0);
    sample();
    // Reset values are 00:00 but disabled, so a tick at 00:00:00 must not ring
    do_tick(0, 0, 0);
    exp_a("no_spurious", 0, 0, 0, 0, 0, 0);
    sample();

    // Out-of-range selector on the 5-channel instance
    sel_b = 3'd5;
    inc_min_b = 1'b1; inc_hour_b = 1'b1; en_toggle_b = 1'b1;
    step();
    exp_b("b_sel5_disp", 0, 0, 0);
    sample();
    for (int i = 0; i < 5; i++) begin
      sel_b = 3'(i);
      exp_b("b_sel5_ignored", 0, 0, 0);
      sample();
    end
    sel_b = 3'd4;
    inc_hour_b = 1'b1; en_toggle_b = 1'b1;
    step();
    exp_b("b_sel4_edit", 1, 0, 1);
    sample();
    sel_b = 3'd7;

    // Wraps on ch0: simultaneous pulses reach 23:59, then wrap each field alone
    for (int k = 0; k < 59; k++) begin
      inc_hour_a = (k < 23);
      inc_min_a  = 1'b1;
      step();
    end
    exp_a("set_2359", 0, 0, 0, 23, 59, 0);
    sample();
    inc_min_a = 1'b1;
    step();
    exp_a("min_wrap", 0, 0, 0, 23, 0, 0);
    sample();
    inc_hour_a = 1'b1;
    step();
    exp_a("hour_wrap", 0, 0, 0, 0, 0, 0);
    sample();

    // ch2 = 07:30 enabled
    sel_a = 2'd2;
    for (int k = 0; k < 30; k++) begin
      inc_hour_a = (k < 7);
      inc_min_a  = 1'b1;
      step();
    end
    en_toggle_a = 1'b1;
    step();
    exp_a("ch2_set", 0, 0, 0, 7, 30, 1);
    sample();
    do_tick(7, 29, 0);
    exp_a("no_match_min", 0, 0, 0, 7, 30, 1);
    sample();
    do_tick(7, 30, 5);
    exp_a("no_match_sec", 0, 0, 0, 7, 30, 1);
    sample();
    do_tick(7, 30, 0);
    exp_a("ring_start", 1, 1, 2, 7, 30, 1);
    sample();
    step();
    exp_a("ring_no_tick", 1, 1, 2, 7, 30, 1);
    sample();
    // Ticks still showing 07:30:00 must not restart the ring
    for (int t = 1; t <= 4; t++) begin
      do_tick(7, 30, 0);
      exp_a("ring_led_toggle", 1, logic'(t % 2 == 0), 2, 7, 30, 1);
      sample();
    end
    do_tick(7, 30, 0);
    exp_a("ring_auto_off", 0, 0, 2, 7, 30, 1);
    sample();

    // ch1 and ch3 both 06:00 enabled
    for (int c = 1; c <= 3; c += 2) begin
      sel_a = 2'(c);
      repeat (6) begin
        inc_hour_a = 1'b1;
        step();
      end
      en_toggle_a = 1'b1;
      step();
    end
    exp_a("ch3_set", 0, 0, 2, 6, 0, 1);
    sample();
    do_tick(6, 0, 0);
    exp_a("lowest_match", 1, 1, 1, 6, 0, 1);
    sample();
    stop = 1'b1;
    step();
    exp_a("stop_ring", 0, 0, 1, 6, 0, 1);
    sample();
    sel_a = 2'd1;
    en_toggle_a = 1'b1;
    step();
    exp_a("ch1_disabled", 0, 0, 1, 6, 0, 0);
    sample();
    do_tick(6, 0, 0);
    exp_a("ring_ch3", 1, 1, 3, 6, 0, 0);
    sample();
    sel_a = 2'd3;

    // Snooze then re-ring after three ticks
    snooze = 1'b1;
    step();
    exp_a("snoozed", 0, 0, 3, 6, 0, 1);
    sample();
    for (int t = 1; t <= 2; t++) begin
      do_tick(6, 0, 0);
      exp_a("snooze_wait", 0, 0, 3, 6, 0, 1);
      sample();
    end
    do_tick(6, 0, 0);
    exp_a("re_ring", 1, 1, 3, 6, 0, 1);
    sample();
    do_tick(6, 0, 0);
    exp_a("re_ring_tick", 1, 0, 3, 6, 0, 1);
    sample();
    stop = 1'b1;
    step();
    exp_a("stop_after_snooze", 0, 0, 3, 6, 0, 1);
    sample();
    stop = 1'b1; snooze = 1'b1;
    step();
    exp_a("idle_stop_snooze", 0, 0, 3, 6, 0, 1);
    sample();

    // stop and snooze together during RING go to IDLE
    do_tick(6, 0, 0);
    exp_a("ring_again", 1, 1, 3, 6, 0, 1);
    sample();
    stop = 1'b1; snooze = 1'b1;
    step();
    exp_a("stop_over_snooze", 0, 0, 3, 6, 0, 1);
    sample();
    for (int t = 1; t <= 4; t++) begin
      do_tick(6, 1, 0);
      exp_a("no_snooze_reentry", 0, 0, 3, 6, 0, 1);
      sample();
    end

    // Editing the ringing channel keeps ringing; disabling it stops the ring
    do_tick(6, 0, 0);
    exp_a("ring_ch3_edit", 1, 1, 3, 6, 0, 1);
    sample();
    inc_min_a = 1'b1;
    step();
    exp_a("edit_during_ring", 1, 1, 3, 6, 1, 1);
    sample();
    en_toggle_a = 1'b1;
    step();
    exp_a("disable_ring_ch", 0, 0, 3, 6, 1, 0);
    sample();

    // Asynchronous reset in the middle of a ring
    sel_a = 2'd2;
    do_tick(7, 30, 0);
    exp_a("ring_pre_rst", 1, 1, 2, 7, 30, 1);
    sample();
    step();
    rst_n = 1'b0;
    exp_a("rst_mid_ring", 0, 0, 0, 0, 0, 0);
    sample();
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      exp_a("rst_clears_a", 0, 0, 0, 0, 0, 0);
      sample();
    end
    for (int i = 0; i < 5; i++) begin
      sel_b = 3'(i);
      exp_b("rst_clears_b", 0, 0, 0);
      sample();
    end
    do_tick(7, 30, 0);
    exp_a("tick_in_rst", 0, 0, 0, 0, 0, 0);
    sample();
    rst_n = 1'b1;
    sel_a = 2'd2;
    do_tick(7, 30, 0);
    exp_a("no_ring_after_rst", 0, 0, 0, 0, 0, 0);
    sample();

    repeat (2) sample();
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_bank.md
ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm channels (1..16).
REQ-002 Parameter RING_SECS, default 60, ticks a ring lasts before auto-off (>=1).
REQ-003 Parameter SNOOZE_SECS, default 300, ticks spent in snooze before re-ring (>=1).
REQ-004 Derived CW = max(1, clog2(NUM_ALARMS)), channel index width.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 tick  input  1  one-clk-wide 1 Hz strobe from the seconds divider.
REQ-008 cur_hour  input  5  current hour, binary 0..23.
REQ-009 cur_min  input  6  current minute, binary 0..59.
REQ-010 cur_sec  input  6  current second, binary 0..59.
REQ-011 sel  input  CW  channel selected for edit and display.
REQ-012 inc_min  input  1  one-clk pulse: selected alarm minute +1.
REQ-013 inc_hour  input  1  one-clk pulse: selected alarm hour +1.
REQ-014 en_toggle  input  1  one-clk pulse: invert enable of selected alarm.
REQ-015 stop  input  1  one-clk pulse: silence ring or cancel snooze.
REQ-016 snooze  input  1  one-clk pulse: defer active ring.
REQ-017 disp_hour  output  5  stored hour of selected alarm.
REQ-018 disp_min  output  6  stored minute of selected alarm.
REQ-019 disp_en  output  1  enable bit of selected alarm.
REQ-020 ring  output  1  high while in RING state.
REQ-021 led  output  1  blink output, toggles each tick while ringing.
REQ-022 ring_ch  output  CW  channel that triggered the current ring/snooze.

Function
REQ-023 Per channel: hour reg (5b), minute reg (6b), enable bit.
REQ-024 inc_min: minute 59->0 wraps, no carry into hour; inc_hour: 23->0 wraps.
REQ-025 Edit pulses with sel >= NUM_ALARMS SHALL be ignored; display outputs then read 0.
REQ-026 disp_* SHALL be combinational from sel and stored regs (zero latency).
REQ-027 Simultaneous inc_min, inc_hour, en_toggle in one cycle SHALL all apply.
REQ-028 FSM states IDLE, RING, SNOOZE; one down-counter CNT shared by RING and SNOOZE.
REQ-029 Match: tick=1, cur_sec=0, channel enabled, cur_hour/cur_min equal stored values.
REQ-030 IDLE + match -> RING next edge; ring_ch = lowest matching index; CNT=RING_SECS-1; led=1.
REQ-031 Matches SHALL be ignored while in RING or SNOOZE.
REQ-032 RING, tick: CNT=0 -> IDLE (ring=0, led=0); else CNT-1 and led toggles.
REQ-033 RING, snooze -> SNOOZE next edge; CNT=SNOOZE_SECS-1; ring=0; led=0.
REQ-034 SNOOZE, tick: CNT=0 -> RING with CNT=RING_SECS-1, led=1; else CNT-1.
REQ-035 stop in RING or SNOOZE -> IDLE next edge; ring=0, led=0; ring_ch holds last value.
REQ-036 Priority same cycle: stop > snooze > tick processing; stop/snooze in IDLE ignored.
REQ-037 en_toggle disabling the channel equal to ring_ch while in RING/SNOOZE -> IDLE, as stop.
REQ-038 Editing time of ring_ch during RING/SNOOZE SHALL not affect the current ring.
REQ-039 ring and led SHALL be registered outputs, asserting one clk after the matching tick.

Reset
REQ-040 rst_n low SHALL immediately force: state IDLE, CNT=0, ring=0, led=0, ring_ch=0.
REQ-041 rst_n low SHALL clear all alarms to 00:00, disabled; reset mid-ring aborts with no further led toggles.
REQ-042 After rst_n rises, first edge behaves as IDLE; no spurious match from reset values.

Verification (RING_SECS=5, SNOOZE_SECS=3, NUM_ALARMS=4)
REQ-043 Set ch2 to 07:30, enable; tick at 07:30:00 -> ring=1, ring_ch=2, led=1 next clk; 5th tick later -> ring=0.
REQ-044 ch1 and ch3 both 06:00 enabled -> ring_ch=1; ch1 disabled -> match at 06:00 gives ring_ch=3.
REQ-045 Ring, snooze pulse -> ring=0; after 3 ticks ring=1 again, led=1; stop then -> IDLE, ring=0.
REQ-046 stop and snooze in same cycle during RING -> IDLE, not SNOOZE.
REQ-047 Minute 59 + inc_min -> 0, hour unchanged; hour 23 + inc_hour -> 0; sel=5 pulses ignored.
REQ-048 rst_n low mid-RING -> ring=0, led=0 immediately; all disp_* read 0 for every sel.
